// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the round-robin Wishbone arbiter:
//   - MAX_MASTERS : largest supported number of requesters
//   - clog2()     : ceiling log2 used for counter and index widths
//   - IDX_W       : width of a master index
//   - arb_state_t : arbiter FSM state encoding
// -----------------------------------------------------------------------------
package wb_arb_pkg;

    localparam int MAX_MASTERS = 32'sd4;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res_v;
        res_v = 32'sd0;
        while ((32'sd1 << res_v) < value) begin
            res_v = res_v + 32'sd1;
        end
        return res_v;
    endfunction

    localparam int IDX_W = clog2(MAX_MASTERS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BUSY    = 2'b01,
        ST_RELEASE = 2'b10,
        ST_TIMEOUT = 2'b11
    } arb_state_t;

endpackage

// File: rtl/wb_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// wb_arb_rr_pick
// Combinational round-robin picker. The winner is the first requester found
// scanning upward from last_grant+1, wrapping modulo NUM_MASTERS.
// Ports:
//   req        in   NUM_MASTERS  request vector
//   last_grant in   IDX_W        index of the most recently granted master
//   grant_oh   out  NUM_MASTERS  one-hot winner (0 when no request)
//   grant_idx  out  IDX_W        binary index of the winner
//   valid      out  1            at least one request present
// -----------------------------------------------------------------------------
module wb_arb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last_grant,
    output logic [NUM_MASTERS-1:0] grant_oh,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   valid
);

    int best_dist_s;
    int best_idx_s;
    int dist_s;

    // Pick the requester with the smallest round-robin distance from last_grant
    always_comb begin
        best_dist_s = NUM_MASTERS;
        best_idx_s  = 32'sd0;
        dist_s      = 32'sd0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            // Distance 0 is the master right after last_grant, NUM_MASTERS-1
            // is last_grant itself, so a lone re-requester can still win.
            dist_s = (i + NUM_MASTERS - 32'sd1 - int'(last_grant)) % NUM_MASTERS;
            best_idx_s  = (req[i] && (dist_s < best_dist_s)) ? i      : best_idx_s;
            best_dist_s = (req[i] && (dist_s < best_dist_s)) ? dist_s : best_dist_s;
        end
        valid     = (best_dist_s < NUM_MASTERS);
        grant_idx = IDX_W'(best_idx_s);
        for (int i = 0; i < NUM_MASTERS; i++) begin
            grant_oh[i] = valid && (best_idx_s == i);
        end
    end

endmodule

// File: rtl/wb_arbiter_rr.sv
// -----------------------------------------------------------------------------
// wb_arbiter_rr
// Round-robin Wishbone arbiter: up to four masters share one slave segment.
// One master owns the segment per bus cycle (cyc high .. cyc low); after it
// releases, the slave side is idled for one cycle so a slave holding ack until
// stb falls can clear it before the next owner starts.
//
// Optional feature macro: WB_ARB_TIMEOUT_EN
//   defined   -> watchdog terminates a transfer that is not acked within
//                TIMEOUT_CYCLES strobe cycles by returning err to the owner.
//   undefined -> no watchdog; an unacked transfer holds the bus.
//
// Ports:
//   wb_clk_i, wb_rst_i            clock, synchronous active-high reset
//   wbm_cyc/stb/we/sel/adr/dat_i  packed per-master requests
//   wbm_dat_o                     read data broadcast (= wbs_dat_i)
//   wbm_ack_o, wbm_err_o          per-master termination, only owner sees them
//   wbs_cyc/stb/we/sel/adr/dat_o  muxed request of the owner
//   wbs_dat_i, wbs_ack_i, wbs_err_i  slave response
//   grant_o                       one-hot registered owner, 0 when not owned
//   busy_o                        FSM not idle
// -----------------------------------------------------------------------------
module wb_arbiter_rr
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BUS_ADDR_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                    wb_clk_i,
    input  logic                                    wb_rst_i,
    input  logic [NUM_MASTERS-1:0]                  wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]                  wbm_stb_i,
    input  logic [NUM_MASTERS-1:0]                  wbm_we_i,
    input  logic [NUM_MASTERS*(BUS_DATA_WIDTH/8)-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS*BUS_ADDR_WIDTH-1:0]   wbm_adr_i,
    input  logic [NUM_MASTERS*BUS_DATA_WIDTH-1:0]   wbm_dat_i,
    output logic [BUS_DATA_WIDTH-1:0]               wbm_dat_o,
    output logic [NUM_MASTERS-1:0]                  wbm_ack_o,
    output logic [NUM_MASTERS-1:0]                  wbm_err_o,
    output logic                                    wbs_cyc_o,
    output logic                                    wbs_stb_o,
    output logic                                    wbs_we_o,
    output logic [BUS_DATA_WIDTH/8-1:0]             wbs_sel_o,
    output logic [BUS_ADDR_WIDTH-1:0]               wbs_adr_o,
    output logic [BUS_DATA_WIDTH-1:0]               wbs_dat_o,
    input  logic [BUS_DATA_WIDTH-1:0]               wbs_dat_i,
    input  logic                                    wbs_ack_i,
    input  logic                                    wbs_err_i,
    output logic [NUM_MASTERS-1:0]                  grant_o,
    output logic                                    busy_o
);

    localparam int BYTE_ENABLES = BUS_DATA_WIDTH / 32'sd8;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 32'sd1);

    generate
        if ((NUM_MASTERS < 32'sd2) || (NUM_MASTERS > MAX_MASTERS) ||
            (TIMEOUT_CYCLES < 32'sd1) || (TIMEOUT_CYCLES > 32'sd65535) ||
            ((BUS_DATA_WIDTH % 32'sd8) != 32'sd0)) begin : g_cfg_error
            $error("wb_arbiter_rr: unsupported parameter combination");
        end
    endgenerate

    arb_state_t               state_r;
    arb_state_t               state_s;
    logic [NUM_MASTERS-1:0]   grant_r;
    logic [NUM_MASTERS-1:0]   grant_s;
    logic [IDX_W-1:0]         last_r;
    logic [IDX_W-1:0]         last_s;
    logic [NUM_MASTERS-1:0]   req_s;
    logic [NUM_MASTERS-1:0]   pick_oh_s;
    logic [IDX_W-1:0]         pick_idx_s;
    logic                     pick_valid_s;
    logic                     own_cyc_s;
    logic                     mux_cyc_s;
    logic                     mux_stb_s;
    logic                     mux_we_s;
    logic [BYTE_ENABLES-1:0]  mux_sel_s;
    logic [BUS_ADDR_WIDTH-1:0] mux_adr_s;
    logic [BUS_DATA_WIDTH-1:0] mux_dat_s;

    assign req_s     = wbm_cyc_i & wbm_stb_i;
    assign own_cyc_s = |(wbm_cyc_i & grant_r);
    assign wbm_dat_o = wbs_dat_i;
    assign grant_o   = grant_r;
    assign busy_o    = (state_r != ST_IDLE);

    wb_arb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_pick (
        .req        (req_s),
        .last_grant (last_r),
        .grant_oh   (pick_oh_s),
        .grant_idx  (pick_idx_s),
        .valid      (pick_valid_s)
    );

    // AND-OR mux of the owner's request; grant_r is one-hot or zero
    always_comb begin
        mux_cyc_s = 1'b0;
        mux_stb_s = 1'b0;
        mux_we_s  = 1'b0;
        mux_sel_s = {BYTE_ENABLES{1'b0}};
        mux_adr_s = {BUS_ADDR_WIDTH{1'b0}};
        mux_dat_s = {BUS_DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_MASTERS; i++) begin
            mux_cyc_s = mux_cyc_s | (wbm_cyc_i[i] & grant_r[i]);
            mux_stb_s = mux_stb_s | (wbm_stb_i[i] & grant_r[i]);
            mux_we_s  = mux_we_s  | (wbm_we_i[i]  & grant_r[i]);
            mux_sel_s = mux_sel_s | (wbm_sel_i[i*BYTE_ENABLES +: BYTE_ENABLES]
                                     & {BYTE_ENABLES{grant_r[i]}});
            mux_adr_s = mux_adr_s | (wbm_adr_i[i*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH]
                                     & {BUS_ADDR_WIDTH{grant_r[i]}});
            mux_dat_s = mux_dat_s | (wbm_dat_i[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH]
                                     & {BUS_DATA_WIDTH{grant_r[i]}});
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = clog2(TIMEOUT_CYCLES + 32'sd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'sd1);

    logic [CNT_W-1:0] wd_cnt_r;
    logic             wd_hit_s;

    // The cycle that would bring the count to TIMEOUT_CYCLES ends the transfer
    assign wd_hit_s = (state_r == ST_BUSY) && wbs_stb_o && !wbs_ack_i &&
                      !wbs_err_i && (wd_cnt_r == CNT_LAST);

    // Watchdog: counts unanswered strobe cycles of the current owner
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wd_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r != ST_BUSY) || wbs_ack_i || wbs_err_i) begin
            wd_cnt_r <= {CNT_W{1'b0}};
        end else if (wbs_stb_o) begin
            wd_cnt_r <= wd_cnt_r + CNT_ONE;
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end
`endif

    // Next-state, grant and last-grant logic
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        last_s  = last_r;
        case (state_r)
            ST_IDLE, ST_RELEASE: begin
                if (pick_valid_s) begin
                    grant_s = pick_oh_s;
                    last_s  = pick_idx_s;
                    state_s = ST_BUSY;
                end else begin
                    grant_s = {NUM_MASTERS{1'b0}};
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Cycle end has priority: the owner is leaving anyway
                if (!own_cyc_s) begin
                    grant_s = {NUM_MASTERS{1'b0}};
                    state_s = ST_RELEASE;
`ifdef WB_ARB_TIMEOUT_EN
                end else if (wd_hit_s) begin
                    state_s = ST_TIMEOUT;
`endif
                end else begin
                    state_s = ST_BUSY;
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            ST_TIMEOUT: begin
                if (!own_cyc_s) begin
                    grant_s = {NUM_MASTERS{1'b0}};
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_TIMEOUT;
                end
            end
`endif
            default: begin
                grant_s = {NUM_MASTERS{1'b0}};
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, grant and last-grant registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r <= ST_IDLE;
            grant_r <= {NUM_MASTERS{1'b0}};
            last_r  <= LAST_RST;
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            last_r  <= last_s;
        end
    end

    // Slave-side request and master-side termination per state
    always_comb begin
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbs_we_o  = 1'b0;
        wbs_sel_o = {BYTE_ENABLES{1'b0}};
        wbs_adr_o = {BUS_ADDR_WIDTH{1'b0}};
        wbs_dat_o = {BUS_DATA_WIDTH{1'b0}};
        wbm_ack_o = {NUM_MASTERS{1'b0}};
        wbm_err_o = {NUM_MASTERS{1'b0}};
        case (state_r)
            ST_BUSY: begin
                wbs_cyc_o = mux_cyc_s;
                wbs_stb_o = mux_stb_s;
                wbs_we_o  = mux_we_s;
                wbs_sel_o = mux_sel_s;
                wbs_adr_o = mux_adr_s;
                wbs_dat_o = mux_dat_s;
                wbm_ack_o = grant_r & {NUM_MASTERS{wbs_ack_i}};
                wbm_err_o = grant_r & {NUM_MASTERS{wbs_err_i}};
            end
`ifdef WB_ARB_TIMEOUT_EN
            ST_TIMEOUT: begin
                // Slave side stays idle; owner gets err for each strobe
                wbm_err_o = grant_r & wbm_stb_i;
            end
`endif
            default: begin
                // IDLE and RELEASE: slave side idle, no termination routed
                wbm_ack_o = {NUM_MASTERS{1'b0}};
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter_rr
// Directed bench for wb_arbiter_rr with four masters and TIMEOUT_CYCLES = 8.
// A table of per-cycle vectors covers round-robin order, reset mid-transfer,
// single write, handover and locked multi-beat cycles; hand-written sequences
// cover the watchdog (or its absence when WB_ARB_TIMEOUT_EN is undefined).
// -----------------------------------------------------------------------------
module tb_wb_arbiter_rr;

    localparam int NM = 4;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int BE = DW / 8;

    logic            clk;
    logic            rst;
    logic [NM-1:0]   cyc;
    logic [NM-1:0]   stb;
    logic [NM-1:0]   we;
    logic [NM*BE-1:0] sel;
    logic [NM*AW-1:0] adr;
    logic [NM*DW-1:0] dat;
    logic [DW-1:0]   m_dat_o;
    logic [NM-1:0]   m_ack;
    logic [NM-1:0]   m_err;
    logic            s_cyc;
    logic            s_stb;
    logic            s_we;
    logic [BE-1:0]   s_sel;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_dat_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack;
    logic            s_err;
    logic [NM-1:0]   grant;
    logic            busy;

    int checks;
    int errors;

    // Fixed per-master request attributes
    logic [AW-1:0] m_adr_c [NM];
    logic [DW-1:0] m_dat_c [NM];
    logic [BE-1:0] m_sel_c [NM];
    logic          m_we_c  [NM];

    typedef struct {
        logic          rst;
        logic [NM-1:0] cyc;
        logic [NM-1:0] stb;
        logic          ack;
        logic [NM-1:0] e_grant;
        logic          e_cyc;
        logic          e_stb;
        logic [NM-1:0] e_ack;
        logic          e_busy;
    } vec_t;

    vec_t vecs[$];

    wb_arbiter_rr #(
        .NUM_MASTERS    (NM),
        .BUS_DATA_WIDTH (DW),
        .BUS_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbm_cyc_i (cyc),
        .wbm_stb_i (stb),
        .wbm_we_i  (we),
        .wbm_sel_i (sel),
        .wbm_adr_i (adr),
        .wbm_dat_i (dat),
        .wbm_dat_o (m_dat_o),
        .wbm_ack_o (m_ack),
        .wbm_err_o (m_err),
        .wbs_cyc_o (s_cyc),
        .wbs_stb_o (s_stb),
        .wbs_we_o  (s_we),
        .wbs_sel_o (s_sel),
        .wbs_adr_o (s_adr),
        .wbs_dat_o (s_dat_o),
        .wbs_dat_i (s_dat_i),
        .wbs_ack_i (s_ack),
        .wbs_err_i (s_err),
        .grant_o   (grant),
        .busy_o    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic [NM-1:0] c, input logic [NM-1:0] s,
                       input logic a, input logic [NM-1:0] eg, input logic ec,
                       input logic es, input logic [NM-1:0] ea, input logic eb);
        vec_t v;
        v.rst = r; v.cyc = c; v.stb = s; v.ack = a;
        v.e_grant = eg; v.e_cyc = ec; v.e_stb = es; v.e_ack = ea; v.e_busy = eb;
        vecs.push_back(v);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_adr_c = '{8'h10, 8'h00, 8'h20, 8'h30};
        m_dat_c = '{32'h1111_1111, 32'hDEAD_BEEF, 32'h2222_2222, 32'h3333_3333};
        m_sel_c = '{4'hF, 4'hF, 4'h3, 4'hC};
        m_we_c  = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < NM; i++) begin
            adr[i*AW +: AW] = m_adr_c[i];
            dat[i*DW +: DW] = m_dat_c[i];
            sel[i*BE +: BE] = m_sel_c[i];
            we[i]           = m_we_c[i];
        end
        s_err   = 1'b0;
        s_ack   = 1'b0;
        s_dat_i = 32'h0;

        // Reset with every master requesting
        rst = 1'b1; cyc = 4'hF; stb = 4'hF;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("reset_grant", 64'(grant), 64'h0);
        chk("reset_busy",  64'(busy),  64'h0);
        chk("reset_cyc",   64'(s_cyc), 64'h0);
        chk("reset_stb",   64'(s_stb), 64'h0);
        chk("reset_ack",   64'(m_ack), 64'h0);
        chk("reset_err",   64'(m_err), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0; cyc = 4'h0; stb = 4'h0;

        // Four continuous requesters: grant order 0,1,2,3,0
        add(1, 4'hF, 4'hF, 0, 4'h0, 0, 0, 4'h0, 0);
        add(0, 4'hF, 4'hF, 0, 4'h0, 0, 0, 4'h0, 0);
        add(0, 4'hF, 4'hF, 1, 4'h1, 1, 1, 4'h1, 1);
        add(0, 4'hE, 4'hE, 0, 4'h1, 0, 0, 4'h0, 1);
        add(0, 4'hF, 4'hF, 0, 4'h0, 0, 0, 4'h0, 1);
        add(0, 4'hF, 4'hF, 1, 4'h2, 1, 1, 4'h2, 1);
        add(0, 4'hD, 4'hD, 0, 4'h2, 0, 0, 4'h0, 1);
        add(0, 4'hF, 4'hF, 0, 4'h0, 0, 0, 4'h0, 1);
        add(0, 4'hF, 4'hF, 1, 4'h4, 1, 1, 4'h4, 1);
        add(0, 4'hB, 4'hB, 0, 4'h4, 0, 0, 4'h0, 1);
        add(0, 4'hF, 4'hF, 0, 4'h0, 0, 0, 4'h0, 1);
        add(0, 4'hF, 4'hF, 1, 4'h8, 1, 1, 4'h8, 1);
        add(0, 4'h7, 4'h7, 0, 4'h8, 0, 0, 4'h0, 1);
        add(0, 4'hF, 4'hF, 0, 4'h0, 0, 0, 4'h0, 1);
        add(0, 4'hF, 4'hF, 0, 4'h1, 1, 1, 4'h0, 1);
        // Reset during BUSY with stb high: nothing delivered afterwards
        add(1, 4'hF, 4'hF, 1, 4'h1, 1, 1, 4'h1, 1);
        add(0, 4'hF, 4'hF, 1, 4'h0, 0, 0, 4'h0, 0);
        add(0, 4'h0, 4'h0, 0, 4'h1, 0, 0, 4'h0, 1);
        add(0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 4'h0, 1);
        add(0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 4'h0, 0);
        // Master 1 writes 0xDEADBEEF to 0x00
        add(0, 4'h2, 4'h2, 0, 4'h0, 0, 0, 4'h0, 0);
        add(0, 4'h2, 4'h2, 1, 4'h2, 1, 1, 4'h2, 1);
        add(0, 4'h0, 4'h0, 0, 4'h2, 0, 0, 4'h0, 1);
        add(0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 4'h0, 1);
        add(0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 4'h0, 0);
        // Masters 0 and 1 together; 0 drops cyc while acked, stale ack in RELEASE
        add(0, 4'h3, 4'h3, 0, 4'h0, 0, 0, 4'h0, 0);
        add(0, 4'h3, 4'h3, 1, 4'h1, 1, 1, 4'h1, 1);
        add(0, 4'h2, 4'h2, 1, 4'h1, 0, 0, 4'h1, 1);
        add(0, 4'h2, 4'h2, 1, 4'h0, 0, 0, 4'h0, 1);
        add(0, 4'h2, 4'h2, 0, 4'h2, 1, 1, 4'h0, 1);
        add(0, 4'h2, 4'h2, 1, 4'h2, 1, 1, 4'h2, 1);
        add(0, 4'h0, 4'h0, 0, 4'h2, 0, 0, 4'h0, 1);
        add(0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 4'h0, 1);
        add(0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 4'h0, 0);
        // Master 0 three reads holding cyc while master 1 waits
        add(0, 4'h3, 4'h3, 0, 4'h0, 0, 0, 4'h0, 0);
        add(0, 4'h3, 4'h3, 1, 4'h1, 1, 1, 4'h1, 1);
        add(0, 4'h3, 4'h3, 1, 4'h1, 1, 1, 4'h1, 1);
        add(0, 4'h3, 4'h3, 1, 4'h1, 1, 1, 4'h1, 1);
        add(0, 4'h3, 4'h2, 0, 4'h1, 1, 0, 4'h0, 1);
        add(0, 4'h2, 4'h2, 0, 4'h1, 0, 0, 4'h0, 1);
        add(0, 4'h2, 4'h2, 0, 4'h0, 0, 0, 4'h0, 1);
        add(0, 4'h2, 4'h2, 0, 4'h2, 1, 1, 4'h0, 1);
        add(0, 4'h2, 4'h2, 1, 4'h2, 1, 1, 4'h2, 1);
        add(0, 4'h0, 4'h0, 0, 4'h2, 0, 0, 4'h0, 1);
        add(0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 4'h0, 1);
        add(0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 4'h0, 0);

        for (int r = 0; r < vecs.size(); r++) begin
            int g;
            rst     = vecs[r].rst;
            cyc     = vecs[r].cyc;
            stb     = vecs[r].stb;
            s_ack   = vecs[r].ack;
            s_dat_i = 32'hC0DE_0000 | 32'(r);
            @(negedge clk);
            chk($sformatf("v%0d_grant", r), 64'(grant), 64'(vecs[r].e_grant));
            chk($sformatf("v%0d_cyc", r),   64'(s_cyc), 64'(vecs[r].e_cyc));
            chk($sformatf("v%0d_stb", r),   64'(s_stb), 64'(vecs[r].e_stb));
            chk($sformatf("v%0d_ack", r),   64'(m_ack), 64'(vecs[r].e_ack));
            chk($sformatf("v%0d_err", r),   64'(m_err), 64'h0);
            chk($sformatf("v%0d_busy", r),  64'(busy),  64'(vecs[r].e_busy));
            chk($sformatf("v%0d_rdat", r),  64'(m_dat_o), 64'(32'hC0DE_0000 | 32'(r)));
            if (vecs[r].e_stb) begin
                g = 0;
                for (int i = 0; i < NM; i++) begin
                    if (vecs[r].e_grant[i]) g = i;
                end
                chk($sformatf("v%0d_adr", r), 64'(s_adr),   64'(m_adr_c[g]));
                chk($sformatf("v%0d_dat", r), 64'(s_dat_o), 64'(m_dat_c[g]));
                chk($sformatf("v%0d_sel", r), 64'(s_sel),   64'(m_sel_c[g]));
                chk($sformatf("v%0d_we", r),  64'(s_we),    64'(m_we_c[g]));
            end
            @(posedge clk);
            #1;
        end

        // Unacknowledged transfer from master 0
        rst = 1'b0; s_ack = 1'b0; cyc = 4'h1; stb = 4'h1;
        @(negedge clk);
        chk("to_req_idle", 64'(busy), 64'h0);
        next_cycle();
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk($sformatf("to_stb_c%0d", c), 64'(s_stb), 64'h1);
            chk($sformatf("to_err_c%0d", c), 64'(m_err), 64'h0);
            next_cycle();
        end
`ifdef WB_ARB_TIMEOUT_EN
        for (int c = 9; c <= 11; c++) begin
            @(negedge clk);
            chk($sformatf("to_err_c%0d", c),   64'(m_err), 64'h1);
            chk($sformatf("to_cyc_c%0d", c),   64'(s_cyc), 64'h0);
            chk($sformatf("to_stb_c%0d", c),   64'(s_stb), 64'h0);
            chk($sformatf("to_grant_c%0d", c), 64'(grant), 64'h1);
            chk($sformatf("to_busy_c%0d", c),  64'(busy),  64'h1);
            chk($sformatf("to_ack_c%0d", c),   64'(m_ack), 64'h0);
            next_cycle();
        end
        stb = 4'h0;
        @(negedge clk);
        chk("to_err_stb_low", 64'(m_err), 64'h0);
        chk("to_hold_busy",   64'(busy),  64'h1);
        next_cycle();
        cyc = 4'h0;
        @(negedge clk);
        chk("to_drop_busy", 64'(busy), 64'h1);
        next_cycle();
        @(negedge clk);
        chk("to_idle_busy",  64'(busy),  64'h0);
        chk("to_idle_grant", 64'(grant), 64'h0);
`else
        for (int c = 9; c <= 100; c++) begin
            @(negedge clk);
            chk($sformatf("nto_busy_c%0d", c),  64'(busy),  64'h1);
            chk($sformatf("nto_stb_c%0d", c),   64'(s_stb), 64'h1);
            chk($sformatf("nto_err_c%0d", c),   64'(m_err), 64'h0);
            chk($sformatf("nto_grant_c%0d", c), 64'(grant), 64'h1);
            next_cycle();
        end
        cyc = 4'h0; stb = 4'h0;
        next_cycle();
        @(negedge clk);
        chk("nto_release_busy",  64'(busy),  64'h1);
        chk("nto_release_grant", 64'(grant), 64'h0);
        next_cycle();
        @(negedge clk);
        chk("nto_idle_busy", 64'(busy), 64'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
